// File: rtl/histogram_accumulator_param.sv
// Per-bin hit histogram with a pipelined read-modify-write, a running maximum tracker,
// a self-timed clear sweep, and a streamed readout port.
module histogram_accumulator_param #(
  parameter int NUM_BINS      = 128,
  parameter int BIN_W         = 7,
  parameter int CNT_W         = 4,
  parameter int SATURATE      = 1,
  parameter int CLEAR_ON_READ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W:0]   bin_tdata,
  input  logic             bin_tvalid,
  output logic             bin_tready,
  input  logic             enable,
  input  logic             clear_req,
  input  logic             readout_req,
  output logic             clear_busy,
  output logic [CNT_W-1:0] rd_tdata,
  output logic [BIN_W-1:0] rd_tbin,
  output logic             rd_tvalid,
  input  logic             rd_tready,
  output logic             rd_tlast,
  output logic [BIN_W-1:0] max_bin,
  output logic [CNT_W-1:0] max_count,
  output logic             max_vld,
  output logic             sat_flag,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_ACCUM = 2'd1, S_DRAIN = 2'd2, S_READOUT = 2'd3} state_t;

  localparam logic [BIN_W-1:0] LAST_ADDR = BIN_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] addr_q, addr_d;
  logic [1:0]       drain_q, drain_d;
  logic             pend_clear_q, pend_clear_d;

  logic [CNT_W-1:0] mem_q [NUM_BINS];

  logic             s1_vld_q, s2_vld_q, s3_vld_q;
  logic [BIN_W-1:0] s1_addr_q, s2_addr_q, s3_addr_q;
  logic [CNT_W-1:0] s2_cnt_q, s3_cnt_q;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  logic             s2_full;

  logic [BIN_W-1:0] max_bin_q;
  logic [CNT_W-1:0] max_count_q;
  logic             sat_q;

  logic hit_acc, rd_acc, addr_last, rd_done, clr_max;

  assign hit_acc   = bin_tvalid & bin_tready;
  assign rd_acc    = rd_tvalid & rd_tready;
  assign addr_last = (addr_q == LAST_ADDR);
  assign rd_done   = (state_q == S_READOUT) & rd_acc & addr_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      addr_q       <= '0;
      drain_q      <= '0;
      pend_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      drain_q      <= drain_d;
      pend_clear_q <= pend_clear_d;
    end
  end

  // Next-state logic; addr_q is shared by the clear sweep and the readout and wraps to 0 after each
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    pend_clear_d = pend_clear_q;
    case (state_q)
      S_CLEAR: begin
        addr_d = addr_q + BIN_W'(1);
        if (addr_last) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (clear_req || readout_req) begin
          state_d      = S_DRAIN;
          drain_d      = 2'd0;
          pend_clear_d = clear_req;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          state_d = pend_clear_q ? S_CLEAR : S_READOUT;
          drain_d = 2'd0;
        end
      end
      S_READOUT: begin
        if (rd_acc) begin
          addr_d = addr_q + BIN_W'(1);
          if (addr_last) state_d = S_ACCUM;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Outputs
  always_comb begin
    clear_busy = rst || (state_q == S_CLEAR);
    bin_tready = !rst && (state_q == S_ACCUM) && enable;
    rd_tvalid  = !rst && (state_q == S_READOUT);
    rd_tbin    = rd_tvalid ? addr_q : '0;
    rd_tdata   = rd_tvalid ? mem_q[addr_q] : '0;
    rd_tlast   = rd_tvalid && addr_last;
    state_dbg  = state_q;
  end

  // Distance-1 hits forward the value being written this cycle; distance-2 hits
  // already see the written value because the array updates on the preceding edge.
  always_comb begin
    s2_full = (s2_cnt_q == CNT_MAX);
    if (s2_full) wr_cnt = (SATURATE != 0) ? CNT_MAX : '0;
    else         wr_cnt = s2_cnt_q + CNT_W'(1);
    if (s2_vld_q && (s2_addr_q == s1_addr_q)) rd_cnt = wr_cnt;
    else                                      rd_cnt = mem_q[s1_addr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s2_addr_q <= '0;
      s3_addr_q <= '0;
      s2_cnt_q  <= '0;
      s3_cnt_q  <= '0;
    end else begin
      s1_vld_q  <= hit_acc & ~bin_tdata[BIN_W];
      s1_addr_q <= bin_tdata[BIN_W-1:0];
      s2_vld_q  <= s1_vld_q;
      s2_addr_q <= s1_addr_q;
      s2_cnt_q  <= rd_cnt;
      s3_vld_q  <= s2_vld_q;
      s3_addr_q <= s2_addr_q;
      s3_cnt_q  <= wr_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR)
      mem_q[addr_q] <= '0;
    else if ((state_q == S_READOUT) && rd_acc && (CLEAR_ON_READ != 0))
      mem_q[addr_q] <= '0;
    else if (s2_vld_q)
      mem_q[s2_addr_q] <= wr_cnt;
  end

  assign max_vld = !rst && s3_vld_q && (s3_cnt_q > max_count_q) &&
                   ((state_q == S_ACCUM) || (state_q == S_DRAIN));
  // Max and sat are already zero on the first CLEAR cycle, even after a drain
  assign clr_max = (state_q == S_CLEAR) || ((state_q == S_DRAIN) && (state_d == S_CLEAR));

  always_ff @(posedge clk) begin
    if (rst || clr_max) begin
      max_count_q <= '0;
      max_bin_q   <= '0;
      sat_q       <= 1'b0;
    end else begin
      if (max_vld) begin
        max_count_q <= s3_cnt_q;
        max_bin_q   <= s3_addr_q;
      end
      if (rd_done && (CLEAR_ON_READ != 0)) begin
        max_count_q <= '0;
        max_bin_q   <= '0;
      end
      if (s2_vld_q && s2_full) sat_q <= 1'b1;
    end
  end

  assign max_count = max_count_q;
  assign max_bin   = max_bin_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_histogram_accumulator_param.sv
// Directed bench for histogram_accumulator_param: a saturating/clear-on-read instance and a
// wrapping/retaining instance driven in lockstep and checked against a small reference model.
module tb_histogram_accumulator_param;

  localparam int NB = 128;
  localparam int BW = 7;
  localparam int CW = 4;
  localparam logic [CW-1:0] FULL = 4'hF;

  logic clk, rst, enable, clear_req, readout_req, rd_tready, bin_tvalid;
  logic [BW:0] bin_tdata;

  logic          bin_tready_a, clear_busy_a, rd_tvalid_a, rd_tlast_a, max_vld_a, sat_flag_a;
  logic [CW-1:0] rd_tdata_a, max_count_a;
  logic [BW-1:0] rd_tbin_a, max_bin_a;
  logic [1:0]    state_a;
  logic          bin_tready_b, clear_busy_b, rd_tvalid_b, rd_tlast_b, max_vld_b, sat_flag_b;
  logic [CW-1:0] rd_tdata_b, max_count_b;
  logic [BW-1:0] rd_tbin_b, max_bin_b;
  logic [1:0]    state_b;

  histogram_accumulator_param #(.NUM_BINS(NB), .BIN_W(BW), .CNT_W(CW), .SATURATE(1), .CLEAR_ON_READ(1)) u_a (
    .clk(clk), .rst(rst), .bin_tdata(bin_tdata), .bin_tvalid(bin_tvalid), .bin_tready(bin_tready_a),
    .enable(enable), .clear_req(clear_req), .readout_req(readout_req), .clear_busy(clear_busy_a),
    .rd_tdata(rd_tdata_a), .rd_tbin(rd_tbin_a), .rd_tvalid(rd_tvalid_a), .rd_tready(rd_tready),
    .rd_tlast(rd_tlast_a), .max_bin(max_bin_a), .max_count(max_count_a), .max_vld(max_vld_a),
    .sat_flag(sat_flag_a), .state_dbg(state_a));

  histogram_accumulator_param #(.NUM_BINS(NB), .BIN_W(BW), .CNT_W(CW), .SATURATE(0), .CLEAR_ON_READ(0)) u_b (
    .clk(clk), .rst(rst), .bin_tdata(bin_tdata), .bin_tvalid(bin_tvalid), .bin_tready(bin_tready_b),
    .enable(enable), .clear_req(clear_req), .readout_req(readout_req), .clear_busy(clear_busy_b),
    .rd_tdata(rd_tdata_b), .rd_tbin(rd_tbin_b), .rd_tvalid(rd_tvalid_b), .rd_tready(rd_tready),
    .rd_tlast(rd_tlast_b), .max_bin(max_bin_b), .max_count(max_count_b), .max_vld(max_vld_b),
    .sat_flag(sat_flag_b), .state_dbg(state_b));

  int total = 0;
  int bad   = 0;
  int vld_a = 0;
  int vld_b = 0;

  logic [CW-1:0] exp_a [NB];
  logic [CW-1:0] exp_b [NB];
  logic [CW-1:0] got_a [NB];
  logic [CW-1:0] got_b [NB];
  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] max_a, max_b;
  logic [BW-1:0] maxbin_a, maxbin_b;
  logic          sat_a, sat_b;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (max_vld_a) vld_a++;
    if (max_vld_b) vld_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < NB; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
    max_a = '0; max_b = '0; maxbin_a = '0; maxbin_b = '0; sat_a = 1'b0; sat_b = 1'b0;
  endtask

  task automatic model_hit(input logic [BW:0] d);
    int idx;
    if (d[BW]) return;
    idx = int'(d[BW-1:0]);
    if (exp_a[idx] == FULL) sat_a = 1'b1;
    else exp_a[idx] = exp_a[idx] + 1'b1;
    if (exp_a[idx] > max_a) begin max_a = exp_a[idx]; maxbin_a = BW'(idx); end
    if (exp_b[idx] == FULL) begin exp_b[idx] = '0; sat_b = 1'b1; end
    else exp_b[idx] = exp_b[idx] + 1'b1;
    if (exp_b[idx] > max_b) begin max_b = exp_b[idx]; maxbin_b = BW'(idx); end
  endtask

  // Driver: n back-to-back hits to one bin
  task automatic send_burst(input logic [BW:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bin_tdata  = d;
      bin_tvalid = 1'b1;
      if (bin_tready_a) model_hit(d);
      tick();
    end
    bin_tvalid = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (clear_busy_a && n < 400) begin n++; tick(); end
    total++;
    if (n !== NB) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, n, NB); end
    total++;
    if (bin_tready_a !== 1'b1 || state_a !== 2'd1) begin
      bad++; $display("FAIL %s_accum_entry got tready=%0b state=%0d exp tready=1 state=1", name, bin_tready_a, state_a);
    end
  endtask

  // Full readout with rd_tready pattern 1,0,0,1 and scoreboard against the model
  task automatic do_readout;
    int beat, k, cyc;
    logic stall, hold_last;
    logic [CW-1:0] hold_d, ev;
    logic [BW-1:0] hold_bin;
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(exp_a[i]);
    readout_req = 1'b1;
    tick();
    readout_req = 1'b0;
    cyc = 0;
    while (!rd_tvalid_a && cyc < 20) begin cyc++; tick(); end
    total++;
    if (cyc !== 3) begin bad++; $display("FAIL readout_drain_len got=%0d exp=3", cyc); end
    if (!rd_tvalid_a) return;
    beat = 0; k = 0; stall = 1'b0;
    hold_d = '0; hold_bin = '0; hold_last = 1'b0;
    while (beat < NB && k < 2000) begin
      rd_tready = ((k % 4) == 0) || ((k % 4) == 3);
      if (stall) begin
        total++;
        if (rd_tdata_a !== hold_d || rd_tbin_a !== hold_bin || rd_tlast_a !== hold_last) begin
          bad++; $display("FAIL stall_hold got bin=%0d data=%0d last=%0b exp bin=%0d data=%0d last=%0b",
                          rd_tbin_a, rd_tdata_a, rd_tlast_a, hold_bin, hold_d, hold_last);
        end
      end
      if (rd_tvalid_a && rd_tready) begin
        ev = exp_q.pop_front();
        total++;
        if (rd_tbin_a !== BW'(beat) || rd_tlast_a !== (beat == NB - 1)) begin
          bad++; $display("FAIL beat_order got bin=%0d last=%0b exp bin=%0d last=%0b",
                          rd_tbin_a, rd_tlast_a, beat, (beat == NB - 1));
        end
        total++;
        if (rd_tdata_a !== ev) begin bad++; $display("FAIL data_a bin=%0d got=%0d exp=%0d", beat, rd_tdata_a, ev); end
        total++;
        if (rd_tdata_b !== exp_b[beat] || rd_tbin_b !== BW'(beat)) begin
          bad++; $display("FAIL data_b bin=%0d got=%0d exp=%0d", beat, rd_tdata_b, exp_b[beat]);
        end
        total++;
        if (bin_tready_a !== 1'b0 || max_vld_a !== 1'b0) begin
          bad++; $display("FAIL readout_quiet got tready=%0b max_vld=%0b exp 0 0", bin_tready_a, max_vld_a);
        end
        got_a[beat] = rd_tdata_a;
        got_b[beat] = rd_tdata_b;
        beat++;
        stall = 1'b0;
      end else begin
        stall = rd_tvalid_a;
        hold_d = rd_tdata_a; hold_bin = rd_tbin_a; hold_last = rd_tlast_a;
      end
      tick();
      k++;
    end
    rd_tready = 1'b0;
    total++;
    if (beat !== NB) begin bad++; $display("FAIL beat_count got=%0d exp=%0d", beat, NB); end
    for (int i = 0; i < NB; i++) exp_a[i] = '0;
    max_a = '0; maxbin_a = '0;
    total++;
    if (rd_tvalid_a !== 1'b0 || state_a !== 2'd1 || max_count_a !== max_a || max_bin_a !== maxbin_a) begin
      bad++; $display("FAIL readout_exit_a got valid=%0b state=%0d max=%0d exp valid=0 state=1 max=0",
                      rd_tvalid_a, state_a, max_count_a);
    end
    total++;
    if (max_count_b !== max_b || max_bin_b !== maxbin_b) begin
      bad++; $display("FAIL readout_exit_b got max=%0d bin=%0d exp max=%0d bin=%0d", max_count_b, max_bin_b, max_b, maxbin_b);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; clear_req = 1'b0; readout_req = 1'b0; rd_tready = 1'b0;
    bin_tvalid = 1'b0; bin_tdata = '0;
    model_reset();
    repeat (3) tick();
    total++;
    if (clear_busy_a !== 1'b1 || bin_tready_a !== 1'b0 || rd_tvalid_a !== 1'b0 || rd_tlast_a !== 1'b0 ||
        rd_tdata_a !== '0 || rd_tbin_a !== '0 || state_a !== 2'd0) begin
      bad++; $display("FAIL reset_ctrl got busy=%0b tready=%0b rvalid=%0b state=%0d exp busy=1 tready=0 rvalid=0 state=0",
                      clear_busy_a, bin_tready_a, rd_tvalid_a, state_a);
    end
    total++;
    if (max_bin_a !== '0 || max_count_a !== '0 || max_vld_a !== 1'b0 || sat_flag_a !== 1'b0) begin
      bad++; $display("FAIL reset_max got bin=%0d cnt=%0d vld=%0b sat=%0b exp all 0", max_bin_a, max_count_a, max_vld_a, sat_flag_a);
    end
    rst = 1'b0;
    #1;
    count_clear("reset");
    total++;
    if (max_count_a !== '0 || max_count_b !== '0) begin
      bad++; $display("FAIL reset_max_after got a=%0d b=%0d exp 0", max_count_a, max_count_b);
    end
  endtask

  task automatic test_basic;
    vld_a = 0; vld_b = 0;
    send_burst(8'h05, 3);
    send_burst(8'h09, 1);
    repeat (6) tick();
    total++;
    if (vld_a !== 3 || vld_b !== 3) begin bad++; $display("FAIL basic_max_vld got a=%0d b=%0d exp 3", vld_a, vld_b); end
    total++;
    if (max_count_a !== 4'd3 || max_bin_a !== 7'd5 || max_count_b !== max_b || max_bin_b !== maxbin_b) begin
      bad++; $display("FAIL basic_max got a=%0d@%0d b=%0d@%0d exp 3@5", max_count_a, max_bin_a, max_count_b, max_bin_b);
    end
    total++;
    if (sat_flag_a !== 1'b0 || sat_flag_b !== 1'b0) begin bad++; $display("FAIL basic_sat got a=%0b b=%0b exp 0", sat_flag_a, sat_flag_b); end
  endtask

  task automatic test_readout;
    int nz;
    do_readout();
    total++;
    if (got_a[5] !== 4'd3 || got_a[9] !== 4'd1 || got_b[5] !== 4'd3 || got_b[9] !== 4'd1) begin
      bad++; $display("FAIL readout_bins got a5=%0d a9=%0d b5=%0d b9=%0d exp 3 1 3 1", got_a[5], got_a[9], got_b[5], got_b[9]);
    end
    do_readout();
    nz = 0;
    for (int i = 0; i < NB; i++) if (got_a[i] != '0) nz++;
    total++;
    if (nz !== 0) begin bad++; $display("FAIL second_readout_zero got nonzero=%0d exp 0", nz); end
    total++;
    if (got_b[5] !== 4'd3) begin bad++; $display("FAIL retained_b5 got=%0d exp 3", got_b[5]); end
  endtask

  task automatic test_saturate;
    send_burst(8'h7F, 20);
    repeat (6) tick();
    total++;
    if (sat_flag_a !== 1'b1 || sat_flag_b !== 1'b1) begin bad++; $display("FAIL sat_flag got a=%0b b=%0b exp 1 1", sat_flag_a, sat_flag_b); end
    total++;
    if (max_count_a !== 4'd15 || max_bin_a !== 7'h7F || max_count_b !== 4'd15 || max_bin_b !== 7'h7F) begin
      bad++; $display("FAIL sat_max got a=%0d@%0d b=%0d@%0d exp 15@127", max_count_a, max_bin_a, max_count_b, max_bin_b);
    end
    do_readout();
    total++;
    if (got_a[127] !== 4'd15 || got_b[127] !== 4'd4) begin
      bad++; $display("FAIL sat_counts got a=%0d b=%0d exp a=15 b=4", got_a[127], got_b[127]);
    end
  endtask

  task automatic test_out_of_range;
    vld_a = 0; vld_b = 0;
    total++;
    if (bin_tready_a !== 1'b1) begin bad++; $display("FAIL oor_ready got=%0b exp 1", bin_tready_a); end
    send_burst(8'h85, 1);
    repeat (6) tick();
    total++;
    if (vld_a !== 0 || vld_b !== 0) begin bad++; $display("FAIL oor_max_vld got a=%0d b=%0d exp 0", vld_a, vld_b); end
    do_readout();
    total++;
    if (got_a[5] !== 4'd0 || got_b[5] !== 4'd3) begin bad++; $display("FAIL oor_bin5 got a=%0d b=%0d exp 0 3", got_a[5], got_b[5]); end
  endtask

  task automatic test_clear_drain;
    int n, m, bad_cyc;
    vld_a = 0; vld_b = 0;
    bin_tdata = 8'h03;
    bin_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bin_tready_a) model_hit(bin_tdata);
      tick();
    end
    clear_req = 1'b1; readout_req = 1'b1;
    if (bin_tready_a) model_hit(bin_tdata);
    tick();
    clear_req = 1'b0; readout_req = 1'b0;
    n = 0;
    while (state_a == 2'd2 && n < 20) begin
      total++;
      if (bin_tready_a !== 1'b0) begin bad++; $display("FAIL drain_tready got=%0b exp 0", bin_tready_a); end
      n++;
      tick();
    end
    total++;
    if (n !== 3) begin bad++; $display("FAIL drain_cycles got=%0d exp 3", n); end
    total++;
    if (vld_a !== 4 || vld_b !== 0) begin bad++; $display("FAIL drain_retire got a=%0d b=%0d exp a=4 b=0", vld_a, vld_b); end
    m = 0; bad_cyc = 0;
    while (clear_busy_a && m < 400) begin
      if (rd_tvalid_a || rd_tvalid_b || max_vld_a || max_vld_b || bin_tready_a) bad_cyc++;
      m++;
      tick();
    end
    bin_tvalid = 1'b0;
    total++;
    if (m !== NB) begin bad++; $display("FAIL clear_cycles got=%0d exp=%0d", m, NB); end
    total++;
    if (bad_cyc !== 0) begin bad++; $display("FAIL clear_quiet got=%0d exp 0", bad_cyc); end
    model_reset();
    total++;
    if (max_count_a !== '0 || max_count_b !== '0 || sat_flag_a !== 1'b0 || sat_flag_b !== 1'b0) begin
      bad++; $display("FAIL clear_max got a=%0d b=%0d sat=%0b%0b exp 0", max_count_a, max_count_b, sat_flag_a, sat_flag_b);
    end
    do_readout();
  endtask

  task automatic test_mid_reset;
    send_burst(8'h07, 2);
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (clear_busy_a !== 1'b1 || bin_tready_a !== 1'b0 || state_a !== 2'd0) begin
      bad++; $display("FAIL mid_reset got busy=%0b tready=%0b state=%0d exp 1 0 0", clear_busy_a, bin_tready_a, state_a);
    end
    rst = 1'b0;
    #1;
    model_reset();
    count_clear("mid_reset");
    do_readout();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_readout();
    test_saturate();
    test_out_of_range();
    test_clear_drain();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
